// File: rtl/dummy_pulpino_write.sv
// Transmit side of the byte-serial flicker protocol: one 32-bit word goes out
// LSB-first as four toggling byte strobes, closed by a four-phase word handshake.
module dummy_pulpino_write #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic [7:0]  out_data,
  output logic        did_word_write_flicker,
  output logic        did_byte_write_flicker,
  input  logic        did_byte_read_flicker,
  input  logic        did_word_read_flicker
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT_BYTE,
    S_WAIT_WORD_ACK,
    S_WAIT_WORD_CLR
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_data, w_data_nxt;
  logic             r_wflag, w_wflag_nxt;
  logic             r_bflag, w_bflag_nxt;
  logic             r_done, w_done_nxt;
  logic             r_terr, w_terr_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_in_ready, r_busy;
  logic [23:0]      r_shift;
  logic             w_load, w_advance, w_waiting;
  logic             w_byte_ack, w_word_ack;

  // Ack synchronisers
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_byte_ack = did_byte_read_flicker;
      assign w_word_ack = did_word_read_flicker;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_byte_sync, r_word_sync;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_byte_sync <= '0;
          r_word_sync <= '0;
        end else begin
          r_byte_sync[0] <= did_byte_read_flicker;
          r_word_sync[0] <= did_word_read_flicker;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_byte_sync[i] <= r_byte_sync[i-1];
            r_word_sync[i] <= r_word_sync[i-1];
          end
        end
      end
      assign w_byte_ack = r_byte_sync[SYNC_STAGES-1];
      assign w_word_ack = r_word_sync[SYNC_STAGES-1];
    end
  endgenerate

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_wflag_nxt = r_wflag;
    w_bflag_nxt = r_bflag;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    w_terr_nxt  = 1'b0;
    w_cnt_nxt   = '0;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_waiting   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_data_nxt  = in_word[7:0];
          w_wflag_nxt = 1'b1;
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_STROBE;
        end
      end
      S_STROBE: begin
        w_bflag_nxt = ~r_bflag;
        w_state_nxt = S_WAIT_BYTE;
      end
      S_WAIT_BYTE: begin
        w_waiting = 1'b1;
        if (w_byte_ack == r_bflag) begin
          if (r_idx == 2'd3) begin
            w_state_nxt = S_WAIT_WORD_ACK;
          end else begin
            w_advance   = 1'b1;
            w_data_nxt  = r_shift[7:0];
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = S_STROBE;
          end
        end
      end
      S_WAIT_WORD_ACK: begin
        w_waiting = 1'b1;
        if (w_word_ack) begin
          w_wflag_nxt = 1'b0;
          w_state_nxt = S_WAIT_WORD_CLR;
        end
      end
      S_WAIT_WORD_CLR: begin
        w_waiting = 1'b1;
        if (!w_word_ack) begin
          w_done_nxt  = 1'b1;
          w_data_nxt  = 8'h00;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A wait that resolves this cycle never aborts; the counter restarts on any state change.
    if (w_waiting && (w_state_nxt == r_state)) begin
      if ((TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST)) begin
        w_state_nxt = S_IDLE;
        w_wflag_nxt = 1'b0;
        w_bflag_nxt = 1'b0;
        w_data_nxt  = 8'h00;
        w_idx_nxt   = 2'd0;
        w_terr_nxt  = 1'b1;
      end else if (TIMEOUT_CYCLES != 0) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_data     <= 8'h00;
      r_wflag    <= 1'b0;
      r_bflag    <= 1'b0;
      r_done     <= 1'b0;
      r_terr     <= 1'b0;
      r_idx      <= 2'd0;
      r_cnt      <= '0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_data     <= w_data_nxt;
      r_wflag    <= w_wflag_nxt;
      r_bflag    <= w_bflag_nxt;
      r_done     <= w_done_nxt;
      r_terr     <= w_terr_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE);
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  // Remaining upper bytes of the accepted word; pure data, so no reset
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_shift <= in_word[31:8];
    end else if (w_advance) begin
      r_shift <= {8'h00, r_shift[23:8]};
    end
  end

  assign in_ready               = r_in_ready;
  assign busy                   = r_busy;
  assign done                   = r_done;
  assign timeout_err            = r_terr;
  assign out_data               = r_data;
  assign did_word_write_flicker = r_wflag;
  assign did_byte_write_flicker = r_bflag;

endmodule

// File: tb/tb_dummy_pulpino_write.sv
// Bench for dummy_pulpino_write: a direct-ack instance and a two-stage-sync
// instance, each talking to a behavioural flicker receiver.
`timescale 1ns/1ps
module tb_dummy_pulpino_write;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] in_word  [2];
  logic        in_valid [2];
  logic        in_ready [2];
  logic        busy     [2];
  logic        done     [2];
  logic        terr     [2];
  logic [7:0]  dat      [2];
  logic        wfl      [2];
  logic        bstr     [2];
  logic        back     [2];
  logic        wack     [2];

  dummy_pulpino_write #(.TIMEOUT_CYCLES(16), .SYNC_STAGES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_word(in_word[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .busy(busy[0]), .done(done[0]), .timeout_err(terr[0]),
    .out_data(dat[0]), .did_word_write_flicker(wfl[0]), .did_byte_write_flicker(bstr[0]),
    .did_byte_read_flicker(back[0]), .did_word_read_flicker(wack[0]));

  dummy_pulpino_write #(.TIMEOUT_CYCLES(16), .SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_word(in_word[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .busy(busy[1]), .done(done[1]), .timeout_err(terr[1]),
    .out_data(dat[1]), .did_word_write_flicker(wfl[1]), .did_byte_write_flicker(bstr[1]),
    .did_byte_read_flicker(back[1]), .did_word_read_flicker(wack[1]));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Receiver model state; received bytes tagged {channel, strobe level, byte}
  int         rx_delay [2];
  bit         mute     [2];
  int         dly      [2];
  int         rcnt     [2];
  int         ecnt     [2];
  int         last_edge[2];
  int         done_cnt [2];
  int         terr_cnt [2];
  logic       prev_bstr[2];
  logic [7:0] prev_dat [2];
  bit         measure = 1'b0;
  logic [9:0] rxq[$];
  int         ivq[$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        back[i] = 1'b0;
        wack[i] = 1'b0;
        dly[i]  = 0;
        rcnt[i] = 0;
        ecnt[i] = 0;
      end else begin
        if (wfl[i] === 1'b1 && bstr[i] !== prev_bstr[i]) begin
          chk($sformatf("stable_before_strobe%0d", i), {24'h0, dat[i]}, {24'h0, prev_dat[i]});
          if (measure && ecnt[i] > 0) ivq.push_back(i * 1000 + (cyc - last_edge[i]));
          last_edge[i] = cyc;
          ecnt[i]++;
        end
        if (wfl[i] !== 1'b1) ecnt[i] = 0;
        if (!mute[i] && bstr[i] !== back[i]) begin
          if (dly[i] >= rx_delay[i]) begin
            back[i] = bstr[i];
            rxq.push_back({i[0], bstr[i], dat[i]});
            rcnt[i]++;
            dly[i] = 0;
          end else begin
            dly[i]++;
          end
        end
        if (wfl[i] === 1'b1 && rcnt[i] == 4) begin
          wack[i] = 1'b1;
        end else if (wfl[i] !== 1'b1) begin
          wack[i] = 1'b0;
          rcnt[i] = 0;
        end
        if (done[i] === 1'b1) done_cnt[i]++;
        if (terr[i] === 1'b1) terr_cnt[i]++;
      end
      prev_bstr[i] = bstr[i];
      prev_dat[i]  = dat[i];
    end
  end

  // Reference: a word is four bytes LSB first, strobe levels 1,0,1,0
  logic [9:0] expq[$];
  int         exp_done[2];

  task automatic expect_word(input int ch, input logic [31:0] w);
    for (int k = 0; k < 4; k++)
      expq.push_back({ch[0], ((k % 2) == 0) ? 1'b1 : 1'b0, w[8*k +: 8]});
    exp_done[ch]++;
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_nbytes"}, rxq.size(), expq.size());
    while (rxq.size() > 0 && expq.size() > 0)
      chk({tag, "_byte"}, {22'h0, rxq.pop_front()}, {22'h0, expq.pop_front()});
    rxq.delete();
    expq.delete();
  endtask

  task automatic send(input int ch, input logic [31:0] w);
    in_word[ch]  = w;
    in_valid[ch] = 1'b1;
    @(negedge clk); #1;
    in_valid[ch] = 1'b0;
  endtask

  task automatic wait_done(input int ch, input int budget, input string tag);
    int start = done_cnt[ch];
    int n = 0;
    while (done_cnt[ch] == start && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk({tag, "_done_seen"}, (done_cnt[ch] != start), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  int          n, t0, ch, gap;
  logic [31:0] w;

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_word[i]  = 32'h0;
      in_valid[i] = 1'b0;
    end
    rst_n = 1'b0;
    idle(3);
    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", in_ready[i], 1);
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_terr", terr[i], 0);
      chk("rst_out_data", dat[i], 0);
      chk("rst_word_flag", wfl[i], 0);
      chk("rst_byte_flag", bstr[i], 0);
    end
    rst_n = 1'b1;
    idle(1);

    // Single word, receiver acks after 2 cycles
    rx_delay[0] = 2;
    send(0, 32'hDEADBEEF);
    expect_word(0, 32'hDEADBEEF);
    chk("t1_busy_during", busy[0], 1);
    wait_done(0, 100, "t1");
    idle(1);
    chk("t1_busy_after", busy[0], 0);
    chk("t1_done_count", done_cnt[0], exp_done[0]);
    check_rx("t1");

    // Back-to-back with in_valid held high
    in_word[0] = 32'h01020304;
    in_valid[0] = 1'b1;
    expect_word(0, 32'h01020304);
    idle(1);
    in_word[0] = 32'hA5A5A5A5;
    expect_word(0, 32'hA5A5A5A5);
    wait_done(0, 100, "t2a");
    chk("t2_ready_with_done", in_ready[0], 1);
    idle(1);
    chk("t2_accept_after_done", busy[0], 1);
    in_valid[0] = 1'b0;
    wait_done(0, 100, "t2b");
    idle(2);
    chk("t2_busy_after", busy[0], 0);
    chk("t2_done_count", done_cnt[0], exp_done[0]);
    check_rx("t2");

    // in_valid while busy is ignored
    send(0, 32'h12345678);
    expect_word(0, 32'h12345678);
    idle(6);
    in_word[0] = 32'h11111111;
    in_valid[0] = 1'b1;
    idle(1);
    in_valid[0] = 1'b0;
    chk("t3_busy_mid", busy[0], 1);
    wait_done(0, 100, "t3");
    idle(4);
    chk("t3_busy_after", busy[0], 0);
    chk("t3_done_count", done_cnt[0], exp_done[0]);
    check_rx("t3");

    // Receiver never acks: abort 16 cycles after entering the byte wait
    mute[0] = 1'b1;
    send(0, 32'hFEEDFACE);
    n = 0;
    while (bstr[0] !== 1'b1 && n < 20) begin idle(1); n++; end
    chk("t4_first_strobe", bstr[0], 1);
    t0 = cyc;
    n = 0;
    while (terr[0] !== 1'b1 && n < 40) begin idle(1); n++; end
    chk("t4_terr_seen", terr[0], 1);
    chk("t4_latency", cyc - t0, 16);
    chk("t4_word_flag", wfl[0], 0);
    chk("t4_byte_flag", bstr[0], 0);
    chk("t4_out_data", dat[0], 0);
    chk("t4_busy", busy[0], 0);
    idle(1);
    chk("t4_terr_width", terr[0], 0);
    chk("t4_terr_count", terr_cnt[0], 1);
    chk("t4_no_done", done_cnt[0], exp_done[0]);
    rxq.delete();
    mute[0] = 1'b0;

    // Asynchronous reset during the second byte
    rx_delay[0] = 2;
    send(0, 32'hCAFEF00D);
    n = 0;
    while (rcnt[0] < 1 && n < 50) begin idle(1); n++; end
    idle(1);
    chk("t5_pre_data", dat[0], 8'hF0);
    chk("t5_pre_word_flag", wfl[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_data", dat[0], 0);
    chk("t5_async_word_flag", wfl[0], 0);
    chk("t5_async_byte_flag", bstr[0], 0);
    chk("t5_async_busy", busy[0], 0);
    chk("t5_async_ready", in_ready[0], 1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    rxq.delete();
    idle(1);
    w = $urandom;
    send(0, w);
    expect_word(0, w);
    wait_done(0, 100, "t5b");
    chk("t5_done_count", done_cnt[0], exp_done[0]);
    check_rx("t5");

    // Zero-delay receiver: direct vs two-stage synchronised acks
    rx_delay[0] = 0;
    rx_delay[1] = 0;
    measure = 1'b1;
    send(0, 32'hDEADBEEF);
    expect_word(0, 32'hDEADBEEF);
    wait_done(0, 100, "t6a");
    send(1, 32'hDEADBEEF);
    expect_word(1, 32'hDEADBEEF);
    wait_done(1, 100, "t6b");
    measure = 1'b0;
    check_rx("t6");
    chk("t6_n_intervals", ivq.size(), 6);
    while (ivq.size() > 0) begin
      n = ivq.pop_front();
      chk($sformatf("t6_byte_period_ch%0d", n / 1000), n % 1000, (n / 1000 == 0) ? 2 : 4);
    end

    // Randomised words, delays and gaps on both instances
    for (int r = 0; r < 12; r++) begin
      ch = r % 2;
      rx_delay[ch] = $urandom_range(0, 3);
      w = $urandom;
      send(ch, w);
      expect_word(ch, w);
      wait_done(ch, 200, "rnd");
      gap = $urandom_range(0, 2);
      idle(gap);
    end
    idle(2);
    check_rx("rnd");
    for (int i = 0; i < 2; i++) begin
      chk("final_done_count", done_cnt[i], exp_done[i]);
      chk("final_busy", busy[i], 0);
    end
    chk("final_terr_count0", terr_cnt[0], 1);
    chk("final_terr_count1", terr_cnt[1], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t reached, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dummy_pulpino_write.md
Name: dummy_pulpino_write

Overview:
Transmit side of the byte-serial flicker protocol that moves one 32-bit word to the pulpino read path over an 8-bit data bus.
- Accepts a word from a local producer and raises the word-write flag.
- Sends four bytes, LSB first, toggling the byte-write flag once per byte and waiting for the receiver's byte-read flag to match.
- Closes with a four-phase word handshake.
- Sits on the host/top-level side, driving the receiver's in_data, did_word_write_flicker and did_byte_write_flicker inputs.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles spent in any wait state before abort; 0 disables the timeout.
- SYNC_STAGES, 0: flop stages on the two ack inputs; 0 = direct, legal range 0..3.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_word  input  32  word to send; sampled only on acceptance
- in_valid  input  1  request to send in_word
- in_ready  output  1  high only in IDLE; a transfer is accepted when in_valid and in_ready are both high
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse on normal completion
- timeout_err  output  1  one-cycle pulse on abort
- out_data  output  8  byte presented to the receiver
- did_word_write_flicker  output  1  word request flag
- did_byte_write_flicker  output  1  byte strobe; toggles once per byte
- did_byte_read_flicker  input  1  receiver byte ack; equals the strobe when the byte is taken
- did_word_read_flicker  input  1  receiver word ack

Behaviour:
- Clock, reset and outputs:
  - One clock domain.
  - rst_n low asynchronously forces: state IDLE; out_data=0x00; both write flags 0; done=0; timeout_err=0; byte index 0; timeout counter 0; sync flops 0.
  - All outputs are registered.
- Ack inputs pass through SYNC_STAGES flops. With 0 stages they are used directly; "ack" below means the post-sync value.
- States: IDLE, STROBE, WAIT_BYTE, WAIT_WORD_ACK, WAIT_WORD_CLR.
- IDLE:
  - in_ready=1.
  - On in_valid=1: latch in_word into the shift register; out_data<=in_word[7:0]; did_word_write_flicker<=1; index<=0; go to STROBE.
  - did_byte_write_flicker is 0 here and stays 0 until STROBE.
- STROBE: did_byte_write_flicker<=~did_byte_write_flicker; go to WAIT_BYTE. Data is therefore stable at least one cycle before every strobe edge.
- WAIT_BYTE:
  - Wait until byte ack == did_byte_write_flicker.
  - If index==3: go to WAIT_WORD_ACK.
  - Else: out_data<=next byte (in_word[15:8], then [23:16], then [31:24]); index++; go to STROBE.
- WAIT_WORD_ACK: on word ack==1, did_word_write_flicker<=0; go to WAIT_WORD_CLR.
- WAIT_WORD_CLR: on word ack==0, done<=1 for one cycle; out_data<=0x00; go to IDLE.
- Strobe parity: after four toggles the byte strobe returns to 0, so every transfer starts with the strobe at 0.
- Minimum writer-side latency (acks already matching): acceptance -> first strobe edge 1 cycle; each byte 2 cycles.
- Timeout:
  - The counter clears on every state change and increments in WAIT_* states.
  - On reaching TIMEOUT_CYCLES: both write flags<=0; out_data<=0x00; timeout_err pulses 1 cycle; go to IDLE.
  - done is not asserted on abort.
- Boundary cases:
  - in_valid while busy is ignored; there is no queue and in_word is not re-sampled.
  - Ack changes in IDLE are ignored.
  - A word ack arriving early, during the byte phase, is not acted on until WAIT_WORD_ACK.
  - in_valid held high through done: a new transfer is accepted on the first IDLE cycle after done.
  - Reset mid-transfer: outputs drop immediately; the receiver requires its own reset to realign.

Test Plan:
1. Reset, then in_word=0xDEADBEEF with in_valid pulsed; bench receiver acks each strobe after 2 cycles -> out_data sequence EF, BE, AD, DE, each stable before its strobe edge; strobe goes 1,0,1,0; done pulses once; busy low afterwards.
2. Back-to-back: 0x01020304 then 0xA5A5A5A5 with in_valid held high -> second word accepted the cycle after done; byte order 04,03,02,01 then A5 x4; strobe starts at 0 for both.
3. in_valid pulsed with 0x11111111 during the byte phase of 0x12345678 -> ignored; only 78,56,34,12 sent; one done pulse.
4. TIMEOUT_CYCLES=16, receiver never acks the first strobe -> timeout_err pulses exactly 16 cycles after entering WAIT_BYTE; flags and out_data return to 0; no done.
5. rst_n asserted mid-byte-2 of 0xCAFEF00D -> outputs clear asynchronously without a clock edge; the next transfer after reset completes normally.
6. SYNC_STAGES=2 with a zero-delay receiver -> same byte order as scenario 1; each WAIT_BYTE lasts 2 cycles longer than with SYNC_STAGES=0.
